prbs_checker: RTL and testbench



---
 rtl/prbs_pkg.sv | 22 ++
 rtl/prbs_lfsr_predict.sv | 32 +++
 rtl/prbs_checker.sv | 166 ++++++++++++++++
 tb/tb_prbs_checker.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared state encoding and standard PRBS feedback taps.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Feedback taps for x^A + x^B + 1.
  localparam int PRBS7_TAP_A  = 7;
  localparam int PRBS7_TAP_B  = 6;
  localparam int PRBS9_TAP_A  = 9;
  localparam int PRBS9_TAP_B  = 5;
  localparam int PRBS15_TAP_A = 15;
  localparam int PRBS15_TAP_B = 14;
  localparam int PRBS23_TAP_A = 23;
  localparam int PRBS23_TAP_B = 18;
  localparam int PRBS31_TAP_A = 31;
  localparam int PRBS31_TAP_B = 28;

endpackage

// File: rtl/prbs_lfsr_predict.sv
// Local PRBS shift register: predicts the next bit and shifts in either the
// received bit (while acquiring) or its own prediction (while locked).
module prbs_lfsr_predict #(
  parameter int ORDER = 7,
  parameter int TAP_A = 7,
  parameter int TAP_B = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic i_shift,      // advance on this cycle
  input  logic i_sel_pred,   // 1: feed back prediction, 0: feed received bit
  input  logic i_bit,        // received bit
  output logic o_pred,       // predicted value of the current received bit
  output logic o_next_zero   // register would be all-zero after this shift
);

  logic [ORDER-1:0] r_s;
  logic [ORDER-1:0] w_s_next;
  logic             w_in;

  assign o_pred      = r_s[TAP_A-1] ^ r_s[TAP_B-1];
  assign w_in        = i_sel_pred ? o_pred : i_bit;
  assign w_s_next    = {r_s[ORDER-2:0], w_in};
  assign o_next_zero = (w_s_next == '0);

  // s[0] holds the newest bit; only valid bits move the register.
  always_ff @(posedge clk) begin
    if (reset)        r_s <= '0;
    else if (i_shift) r_s <= w_s_next;
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS bit-error-rate checker: self-seeds from the received stream, verifies,
// locks, then counts bits/errors with windowed loss-of-lock detection.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int PRBS_ORDER = 7,
  parameter int TAP_A      = PRBS7_TAP_A,
  parameter int TAP_B      = PRBS7_TAP_B,
  parameter int LOCK_COUNT = 32,
  parameter int WINDOW     = 64,
  parameter int LOSS_ERRS  = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_in_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             saturated
);

  localparam int FILL_W  = $clog2(PRBS_ORDER + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

  state_e             r_state, w_state_next;
  logic [FILL_W-1:0]  r_fill,  w_fill_next;
  logic [MATCH_W-1:0] r_match, w_match_next;
  logic [WIN_W-1:0]   r_win,   w_win_next;
  logic [WERR_W-1:0]  r_werr,  w_werr_next;
  logic               r_locked;

  logic [CNT_W-1:0]   r_bit_cnt, r_err_cnt, w_bit_nx, w_err_nx;
  logic               r_pulse, r_sat;

  logic w_pred, w_next_zero, w_mis, w_cnt_en, w_err;

  assign w_mis = data_in ^ w_pred;

  prbs_lfsr_predict #(
    .ORDER (PRBS_ORDER),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_lfsr (
    .clk         (clk),
    .reset       (reset),
    .i_shift     (data_in_valid),
    .i_sel_pred  (r_state == LOCKED),
    .i_bit       (data_in),
    .o_pred      (w_pred),
    .o_next_zero (w_next_zero)
  );

  // State and acquisition/window registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SEED;
      r_fill   <= '0;
      r_match  <= '0;
      r_win    <= '0;
      r_werr   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_fill   <= w_fill_next;
      r_match  <= w_match_next;
      r_win    <= w_win_next;
      r_werr   <= w_werr_next;
      r_locked <= (w_state_next == LOCKED);
    end
  end

  // Next-state: seed fill, verify run length, locked window error tracking.
  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    w_match_next = r_match;
    w_win_next   = r_win;
    w_werr_next  = r_werr;
    w_cnt_en     = 1'b0;
    w_err        = 1'b0;
    if (data_in_valid) begin
      case (r_state)
        SEED: begin
          if (r_fill == FILL_W'(PRBS_ORDER - 1)) begin
            w_fill_next = '0;
            // An all-zero seed is the LFSR lock-up state; refill instead.
            if (!w_next_zero) begin
              w_state_next = VERIFY;
              w_match_next = '0;
            end
          end else begin
            w_fill_next = r_fill + FILL_W'(1);
          end
        end
        VERIFY: begin
          if (w_mis) begin
            w_state_next = SEED;
            w_fill_next  = '0;
            w_match_next = '0;
          end else if (r_match == MATCH_W'(LOCK_COUNT - 1)) begin
            w_state_next = LOCKED;
            w_win_next   = '0;
            w_werr_next  = '0;
          end else begin
            w_match_next = r_match + MATCH_W'(1);
          end
        end
        LOCKED: begin
          w_cnt_en = 1'b1;
          w_err    = w_mis;
          if (r_win == WIN_W'(WINDOW - 1)) begin
            w_win_next  = '0;
            w_werr_next = WERR_W'(w_mis);
          end else begin
            w_win_next  = r_win + WIN_W'(1);
            w_werr_next = r_werr + WERR_W'(w_mis);
          end
          if (w_werr_next >= WERR_W'(LOSS_ERRS)) begin
            w_state_next = SEED;
            w_fill_next  = '0;
          end
        end
        default: begin
          w_state_next = SEED;
          w_fill_next  = '0;
        end
      endcase
    end
  end

  // Saturating increments for the measurement counters.
  always_comb begin
    w_bit_nx = r_bit_cnt;
    w_err_nx = r_err_cnt;
    if (w_cnt_en && !(&r_bit_cnt)) w_bit_nx = r_bit_cnt + CNT_W'(1);
    if (w_err    && !(&r_err_cnt)) w_err_nx = r_err_cnt + CNT_W'(1);
  end

  // Counters, error pulse and sticky saturation; clear wins over counting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
      r_pulse   <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_bit_cnt <= w_bit_nx;
      r_err_cnt <= w_err_nx;
      r_pulse   <= w_err;
      r_sat     <= r_sat | (&w_bit_nx) | (&w_err_nx);
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_pulse;
  assign bit_count = r_bit_cnt;
  assign err_count = r_err_cnt;
  assign saturated = r_sat;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: table-driven error-injection scenarios, directed
// corner sequences and a randomized run, all against a queue-based model.
module tb_prbs_checker;

  localparam int N   = 7;
  localparam int TA  = 7;
  localparam int TB  = 6;
  localparam int LC  = 32;
  localparam int WIN = 64;
  localparam int LE  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1, data_in = 1'b0, data_in_valid = 1'b0, clear = 1'b0;
  logic        locked, err_pulse, saturated;
  logic [31:0] bit_count, err_count;
  logic        locked4, err_pulse4, saturated4;
  logic [3:0]  bit_count4, err_count4;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .clear(clear), .locked(locked), .err_pulse(err_pulse),
    .bit_count(bit_count), .err_count(err_count), .saturated(saturated)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .clear(clear), .locked(locked4), .err_pulse(err_pulse4),
    .bit_count(bit_count4), .err_count(err_count4), .saturated(saturated4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- PRBS7 source: b[n] = b[n-7] ^ b[n-6] ----------------
  bit g[$];
  function bit gen_next();
    bit b;
    b = g[0] ^ g[1];
    void'(g.pop_front());
    g.push_back(b);
    return b;
  endfunction

  // ---------------- Reference model ----------------
  // mq holds the recent reconstructed sequence, oldest first.
  bit     mq[$];
  int     mmode;      // 0 acquire, 1 verify, 2 locked
  int     mmatch, mn, mwin_id, mwin_errs;
  longint mbits, merrs;
  bit     mpulse;

  function bit mpred();
    return mq[mq.size()-TA] ^ mq[mq.size()-TB];
  endfunction

  task automatic model_reset();
    mq.delete();
    mmode = 0; mmatch = 0; mn = 0; mwin_id = 0; mwin_errs = 0;
    mbits = 0; merrs = 0; mpulse = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit p, e, zero;
    int id;
    mpulse = 0;
    if (c) begin mbits = 0; merrs = 0; end
    if (v) begin
      case (mmode)
        0: begin
          mq.push_back(d);
          if (mq.size() == N) begin
            zero = 1;
            foreach (mq[i]) if (mq[i]) zero = 0;
            if (zero) mq.delete();
            else begin mmode = 1; mmatch = 0; end
          end
        end
        1: begin
          p = mpred();
          mq.push_back(d);
          void'(mq.pop_front());
          if (d == p) begin
            mmatch++;
            if (mmatch == LC) begin
              mmode = 2; mn = 0; mwin_id = 0; mwin_errs = 0;
            end
          end else begin
            mmode = 0; mq.delete();
          end
        end
        default: begin
          p = mpred();
          mq.push_back(p);
          void'(mq.pop_front());
          e = (d != p);
          id = (mn + 1) / WIN;
          if (id != mwin_id) begin mwin_id = id; mwin_errs = 0; end
          if (e) mwin_errs++;
          mn++;
          if (!c) begin
            mbits++;
            if (e) begin merrs++; mpulse = 1; end
          end
          if (mwin_errs >= LE) begin mmode = 0; mq.delete(); end
        end
      endcase
    end
  endtask

  task automatic cmp_model();
    longint b4, e4;
    b4 = (mbits > 15) ? 15 : mbits;
    e4 = (merrs > 15) ? 15 : merrs;
    chk("m_locked",    locked,     (mmode == 2));
    chk("m_err_pulse", err_pulse,  mpulse);
    chk("m_bit_count", bit_count,  mbits);
    chk("m_err_count", err_count,  merrs);
    chk("m_saturated", saturated,  0);
    chk("m4_locked",   locked4,    (mmode == 2));
    chk("m4_bit_count", bit_count4, b4);
    chk("m4_err_count", err_count4, e4);
    chk("m4_saturated", saturated4, (mbits >= 15 || merrs >= 15));
  endtask

  // ---------------- Drivers ----------------
  task automatic step(input bit v, input bit d, input bit c);
    data_in_valid = v; data_in = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    cmp_model();
    data_in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) step(1'b1, gen_next(), 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; data_in_valid = 1'b1; data_in = gen_next();
    @(posedge clk);
    model_reset();
    #1;
    cmp_model();
    reset = 1'b0; data_in_valid = 1'b0;
  endtask

  // Error-injection scenarios; n counts locked valid bits from 0.
  typedef struct {
    string name;
    int    start;
    int    nflip;
    int    gap;
    bit    exp_lock;
    int    exp_err;
    int    exp_bits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, nv, last;
    bit flip, v, d, c;

    vecs[0] = '{"single_flip",      100,  1, 1, 1'b1,  1, 101};
    vecs[1] = '{"seven_in_window",  100,  7, 3, 1'b1,  7, 119};
    vecs[2] = '{"eight_in_window",  100,  8, 3, 1'b0,  8, 122};
    vecs[3] = '{"eight_across_wrap", 58,  8, 1, 1'b1,  8,  66};
    vecs[4] = '{"seven_per_window", 120, 14, 1, 1'b1, 14, 134};
    vecs[5] = '{"eighth_in_next",   120, 15, 1, 1'b0, 15, 135};

    repeat (N) g.push_back(1'b1);
    model_reset();

    // Reset values
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_saturated", saturated, 0);

    // Clean stream: lock latency and error-free counting
    send_clean(38);
    chk("lat_38", locked, 0);
    send_clean(1);
    chk("lat_39", locked, 1);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      send_clean(1);
      pulses += int'(err_pulse);
    end
    chk("clean_bits", bit_count, 1000);
    chk("clean_errs", err_count, 0);
    chk("clean_pulses", pulses, 0);

    // Table-driven error injection
    foreach (vecs[k]) begin
      do_reset();
      send_clean(39);
      chk({vecs[k].name, "_lock"}, locked, 1);
      pulses = 0;
      last = vecs[k].start + (vecs[k].nflip - 1) * vecs[k].gap;
      for (int n = 0; n <= last; n++) begin
        flip = (n >= vecs[k].start) && ((n - vecs[k].start) % vecs[k].gap == 0) &&
               ((n - vecs[k].start) / vecs[k].gap < vecs[k].nflip);
        step(1'b1, gen_next() ^ flip, 1'b0);
        pulses += int'(err_pulse);
      end
      chk({vecs[k].name, "_locked"}, locked, vecs[k].exp_lock);
      chk({vecs[k].name, "_errs"}, err_count, vecs[k].exp_err);
      chk({vecs[k].name, "_bits"}, bit_count, vecs[k].exp_bits);
      chk({vecs[k].name, "_pulses"}, pulses, vecs[k].exp_err);
      if (!vecs[k].exp_lock) begin
        send_clean(38);
        chk({vecs[k].name, "_relock38"}, locked, 0);
        send_clean(1);
        chk({vecs[k].name, "_relock39"}, locked, 1);
        chk({vecs[k].name, "_held_errs"}, err_count, vecs[k].exp_err);
      end else begin
        send_clean(100);
        chk({vecs[k].name, "_noprop_errs"}, err_count, vecs[k].exp_err);
        chk({vecs[k].name, "_still_locked"}, locked, 1);
      end
    end

    // All-zero input never locks
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
    chk("zero_nolock", locked, 0);

    // Gapped clean stream: lock after 39 valid bits, counts only valid bits
    do_reset();
    for (int i = 1; i <= 39; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      send_clean(1);
      if (i == 38) chk("gap_lat_38", locked, 0);
    end
    chk("gap_lat_39", locked, 1);
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom_range(0, 1));
      d = v ? gen_next() : 1'($urandom_range(0, 1));
      step(v, d, 1'b0);
      nv += int'(v);
    end
    chk("gap_bits", bit_count, nv);
    chk("gap_errs", err_count, 0);

    // Saturation on the 4-bit instance and clear priority
    do_reset();
    send_clean(39 + 20);
    chk("sat_bits4", bit_count4, 15);
    chk("sat_flag4", saturated4, 1);
    chk("sat_bits32", bit_count, 20);
    step(1'b1, gen_next(), 1'b1);
    chk("clr_bits4", bit_count4, 0);
    chk("clr_flag4", saturated4, 0);
    chk("clr_bits32", bit_count, 0);
    chk("clr_locked", locked, 1);
    send_clean(1);
    chk("post_clr_bits", bit_count, 1);

    // Reset while locked, with an error pulse pending
    do_reset();
    send_clean(39 + 50);
    step(1'b1, gen_next() ^ 1'b1, 1'b0);
    chk("pre_rst_pulse", err_pulse, 1);
    do_reset();
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_pulse", err_pulse, 0);
    chk("mid_rst_bits", bit_count, 0);
    chk("mid_rst_errs", err_count, 0);
    send_clean(38);
    chk("mid_rst_relock38", locked, 0);
    send_clean(1);
    chk("mid_rst_relock39", locked, 1);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 2) do_reset();
      else begin
        v = ($urandom_range(0, 9) < 8);
        d = v ? (gen_next() ^ ($urandom_range(0, 59) == 0)) : 1'($urandom_range(0, 1));
        c = ($urandom_range(0, 199) == 0);
        step(v, d, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
